// File: rtl/arbiter_out_fifo.sv
// arbiter_out_fifo: first-word-fall-through elastic buffer after the priority arbiter.
// Define ARBITER_OUT_FIFO_STATS_EN to add the max_count and stall_cycles monitor outputs.
module arbiter_out_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4,
    parameter int CWIDTH = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready,
`ifdef ARBITER_OUT_FIFO_STATS_EN
    output logic [CWIDTH-1:0] count,
    output logic [CWIDTH-1:0] max_count,
    output logic [31:0]       stall_cycles
`else
    output logic [CWIDTH-1:0] count
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CWIDTH-1:0] count_q, count_d;
    logic              push, pop;

    // Flags come only from count_q, so in_ready never depends on out_ready.
    assign in_ready  = count_q != CWIDTH'(DEPTH);
    assign out_valid = count_q != '0;
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d = (push && !pop) ? count_q + CWIDTH'(1) :
                  (!push && pop) ? count_q - CWIDTH'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

`ifdef ARBITER_OUT_FIFO_STATS_EN
    logic [CWIDTH-1:0] max_q;
    logic [31:0]       stall_q;

    assign max_count    = max_q;
    assign stall_cycles = stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_q   <= '0;
            stall_q <= '0;
        end else begin
            if (count_d > max_q) max_q <= count_d;
            if (in_valid && !in_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
        end
    end
`endif
endmodule
